result_reader: RTL and testbench
================================

RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter: ADDR_W, default 9, SRAM word address width (512 words).
REQ-002 Parameter: MEM_WORD_SIZE, default 64, stored word width (two 32-bit SRAM macros side by side).
REQ-003 Parameter: DATA_W, default 32, output beat width; MEM_WORD_SIZE SHALL equal 2*DATA_W.
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 start_i  input  1  single-cycle request to begin a dump; honoured only in IDLE.
REQ-007 rd_start_addr_i  input  ADDR_W  first word address of the dump range.
REQ-008 rd_end_addr_i  input  ADDR_W  last word address of the dump range (inclusive).
REQ-009 read_o  output  1  SRAM read-port enable, active-high (drives the read-only port chip select through inversion).
REQ-010 r_addr_o  output  ADDR_W  SRAM read-port address.
REQ-011 r_data_i  input  MEM_WORD_SIZE  concatenated SRAM read data {high macro, low macro}.
REQ-012 out_valid_o  output  1  output beat valid.
REQ-013 out_ready_i  input  1  downstream accepts beat; a transfer occurs when out_valid_o and out_ready_i are both 1 on a rising edge.
REQ-014 out_data_o  output  DATA_W  output beat data.
REQ-015 out_last_o  output  1  marks the final beat of the dump.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse when a dump completes.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, CAPTURE, SEND_LO, SEND_HI, DONE.
REQ-019 IDLE with start_i=1 SHALL latch both addresses, load cur_addr=rd_start_addr_i and go to ISSUE, unless rd_start_addr_i > rd_end_addr_i, in which case it SHALL go to DONE with no reads and no beats.
REQ-020 ISSUE SHALL assert read_o=1 with r_addr_o=cur_addr for exactly one cycle, then go to CAPTURE.
REQ-021 CAPTURE SHALL register r_data_i (valid in the cycle after ISSUE) into a word register at the end of the cycle, then go to SEND_LO.
REQ-022 SEND_LO SHALL drive out_valid_o=1, out_data_o=word[DATA_W-1:0], out_last_o=0; on transfer go to SEND_HI.
REQ-023 SEND_HI SHALL drive out_valid_o=1, out_data_o=word[MEM_WORD_SIZE-1:DATA_W], out_last_o=(cur_addr==end address); on transfer go to DONE if last, else increment cur_addr and go to ISSUE.
REQ-024 While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o SHALL hold stable; no SRAM read SHALL be issued.
REQ-025 DONE SHALL assert done_o=1 for one cycle and return to IDLE.
REQ-026 read_o SHALL be 0 in every state except ISSUE; r_addr_o SHALL hold its last value outside ISSUE.
REQ-027 The last-word comparison SHALL occur before increment, so rd_end_addr_i=2^ADDR_W-1 completes without address wrap.
REQ-028 start_i while busy_o=1 SHALL be ignored; address input changes during a dump SHALL have no effect.
REQ-029 With out_ready_i held 1, throughput SHALL be exactly 4 cycles per word; a range of N words SHALL complete in 4N+1 cycles from start_i to done_o.
REQ-030 out_valid_o SHALL be 0 in IDLE, ISSUE, CAPTURE, DONE.

Reset
REQ-031 rst_i=1 at a rising edge SHALL force IDLE from any state, including mid-dump, aborting without done_o.
REQ-032 After reset: read_o=0, r_addr_o=0, out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, done_o=0, word register=0.

Verification
REQ-033 Start 5, end 5, ready=1, SRAM[5]=0xDEADBEEF_12345678 -> read_o one cycle at addr 5; beats 0x12345678 then 0xDEADBEEF (last=1); done_o 5 cycles after start.
REQ-034 Start 10, end 13, ready=1 -> reads at 10,11,12,13 spaced 4 cycles; 8 beats low/high order; last only on beat 8; done_o at cycle 17.
REQ-035 Start 2, end 3, ready toggled 0/1 every 3 cycles -> beats held stable while stalled; no read issued during stall; 4 beats, data correct.
REQ-036 Start 511, end 511 -> single read at 511, 2 beats, done_o, cur_addr never wraps to 0 and no extra read.
REQ-037 Start 20, end 19 -> no read_o, no out_valid_o, done_o pulse one cycle after start.
REQ-038 Reset asserted in SEND_HI of word 2 of range 0..7 -> next cycle all outputs 0, IDLE; new start 0..0 then completes normally.

Source files
------------

// File: rtl/result_reader.sv
// Streams a range of 64-bit SRAM words out as 32-bit beats, low half first.
// One word is in flight at a time: issue, capture, send low, send high.
module result_reader #(
    parameter int ADDR_W        = 9,
    parameter int MEM_WORD_SIZE = 64,
    parameter int DATA_W        = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        rd_start_addr_i,
    input  logic [ADDR_W-1:0]        rd_end_addr_i,
    output logic                     read_o,
    output logic [ADDR_W-1:0]        r_addr_o,
    input  logic [MEM_WORD_SIZE-1:0] r_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND_LO,
        SEND_HI,
        DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [ADDR_W-1:0]        cur_q;
    logic [ADDR_W-1:0]        cur_d;
    logic [ADDR_W-1:0]        end_q;
    logic [ADDR_W-1:0]        end_d;
    logic [ADDR_W-1:0]        raddr_q;
    logic [MEM_WORD_SIZE-1:0] word_q;
    logic                     is_last;
    logic                     xfer;

    // Compared before any increment, so an end address of all-ones never wraps.
    assign is_last = (cur_q == end_q);
    assign xfer    = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_d = rd_start_addr_i;
                    end_d = rd_end_addr_i;
                    if (rd_start_addr_i > rd_end_addr_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d = SEND_LO;
            end
            SEND_LO: begin
                if (xfer) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                if (xfer) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        read_o      = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        unique case (state_q)
            ISSUE: begin
                read_o = 1'b1;
            end
            SEND_LO: begin
                out_valid_o = 1'b1;
                out_data_o  = word_q[DATA_W-1:0];
            end
            SEND_HI: begin
                out_valid_o = 1'b1;
                out_data_o  = word_q[MEM_WORD_SIZE-1:DATA_W];
                out_last_o  = is_last;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address is live during ISSUE and holds its last value otherwise.
    assign r_addr_o = (state_q == ISSUE) ? cur_q : raddr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            raddr_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            if (state_q == ISSUE) begin
                raddr_q <= cur_q;
            end
            if (state_q == CAPTURE) begin
                word_q <= r_data_i;
            end
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader with a one-cycle-latency SRAM model.
// Each test task drives a scenario and checks it inline.
module tb_result_reader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [8:0]  rd_start_addr_i;
    logic [8:0]  rd_end_addr_i;
    logic        read_o;
    logic [8:0]  r_addr_o;
    logic [63:0] r_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;

    int cmp = 0;
    int mism = 0;

    logic [63:0] mem [512];

    logic [8:0]  rd_addr [$];
    int          rd_cyc  [$];
    logic [31:0] bt_data [$];
    logic        bt_last [$];
    int          done_cyc;
    int          valid_cnt;
    int          stall_cyc;
    int          stall_viol;
    int          stall_read;
    bit          timeout;

    result_reader dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .rd_start_addr_i (rd_start_addr_i),
        .rd_end_addr_i   (rd_end_addr_i),
        .read_o          (read_o),
        .r_addr_o        (r_addr_o),
        .r_data_i        (r_data_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_data_o      (out_data_o),
        .out_last_o      (out_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (read_o) r_data_i <= mem[r_addr_o];
    end

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic dump(input logic [8:0] s, input logic [8:0] e,
                        input bit stall, input bit poke);
        int          cyc;
        bit          prev_stall;
        bit          fin;
        logic [31:0] pd;
        logic        pl;
        rd_addr.delete();
        rd_cyc.delete();
        bt_data.delete();
        bt_last.delete();
        done_cyc   = -1;
        valid_cnt  = 0;
        stall_cyc  = 0;
        stall_viol = 0;
        stall_read = 0;
        timeout    = 0;
        prev_stall = 0;
        fin        = 0;
        pd         = '0;
        pl         = 1'b0;
        step();
        rd_start_addr_i = s;
        rd_end_addr_i   = e;
        start_i         = 1'b1;
        out_ready_i     = 1'b1;
        cyc             = 0;
        while (!fin) begin
            step();
            cyc++;
            start_i         = (poke && cyc == 3);
            rd_start_addr_i = 9'd0;
            rd_end_addr_i   = 9'd511;
            out_ready_i = stall ? 1'(((cyc + 2) / 3) % 2) : 1'b1;
            if (prev_stall) begin
                if (!out_valid_o || out_data_o !== pd || out_last_o !== pl)
                    stall_viol++;
                if (read_o) stall_read++;
            end
            if (read_o) begin
                rd_addr.push_back(r_addr_o);
                rd_cyc.push_back(cyc);
            end
            if (out_valid_o) valid_cnt++;
            if (out_valid_o && !out_ready_i) stall_cyc++;
            if (out_valid_o && out_ready_i) begin
                bt_data.push_back(out_data_o);
                bt_last.push_back(out_last_o);
            end
            prev_stall = out_valid_o && !out_ready_i;
            pd = out_data_o;
            pl = out_last_o;
            if (done_o) begin
                done_cyc = cyc;
                fin = 1;
            end else if (cyc >= 200) begin
                timeout = 1;
                fin = 1;
            end
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        step();
        step();
        cmp++; if (read_o !== 1'b0) begin mism++;
            $display("FAIL reset_read: got %0h want 0", read_o); end
        cmp++; if (r_addr_o !== 9'd0) begin mism++;
            $display("FAIL reset_addr: got %0h want 0", r_addr_o); end
        cmp++; if (out_valid_o !== 1'b0) begin mism++;
            $display("FAIL reset_valid: got %0h want 0", out_valid_o); end
        cmp++; if (out_data_o !== 32'd0) begin mism++;
            $display("FAIL reset_data: got %0h want 0", out_data_o); end
        cmp++; if (out_last_o !== 1'b0) begin mism++;
            $display("FAIL reset_last: got %0h want 0", out_last_o); end
        cmp++; if (busy_o !== 1'b0) begin mism++;
            $display("FAIL reset_busy: got %0h want 0", busy_o); end
        cmp++; if (done_o !== 1'b0) begin mism++;
            $display("FAIL reset_done: got %0h want 0", done_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_single;
        dump(9'd5, 9'd5, 0, 0);
        cmp++; if (timeout !== 1'b0) begin mism++;
            $display("FAIL single_timeout: got %0d want 0", timeout); end
        cmp++; if (rd_addr.size() !== 1) begin mism++;
            $display("FAIL single_nreads: got %0d want 1", rd_addr.size()); end
        else begin
            cmp++; if (rd_addr[0] !== 9'd5 || rd_cyc[0] !== 1) begin mism++;
                $display("FAIL single_read: got addr %0d cyc %0d want 5 1",
                         rd_addr[0], rd_cyc[0]); end
        end
        cmp++; if (bt_data.size() !== 2) begin mism++;
            $display("FAIL single_nbeats: got %0d want 2", bt_data.size()); end
        else begin
            cmp++; if (bt_data[0] !== 32'h12345678 || bt_last[0] !== 1'b0) begin
                mism++;
                $display("FAIL single_beat0: got %h/%0d want 12345678/0",
                         bt_data[0], bt_last[0]); end
            cmp++; if (bt_data[1] !== 32'hDEADBEEF || bt_last[1] !== 1'b1) begin
                mism++;
                $display("FAIL single_beat1: got %h/%0d want deadbeef/1",
                         bt_data[1], bt_last[1]); end
        end
        cmp++; if (done_cyc !== 5) begin mism++;
            $display("FAIL single_done_cyc: got %0d want 5", done_cyc); end
        step();
        cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin mism++;
            $display("FAIL single_after: got done %0d busy %0d want 0 0",
                     done_o, busy_o); end
    endtask

    task automatic test_multi;
        logic [31:0] exp_d;
        dump(9'd10, 9'd13, 0, 1);
        cmp++; if (timeout !== 1'b0) begin mism++;
            $display("FAIL multi_timeout: got %0d want 0", timeout); end
        cmp++; if (rd_addr.size() !== 4) begin mism++;
            $display("FAIL multi_nreads: got %0d want 4", rd_addr.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                cmp++;
                if (rd_addr[i] !== 9'(10 + i) || rd_cyc[i] !== 1 + 4 * i) begin
                    mism++;
                    $display("FAIL multi_read%0d: got addr %0d cyc %0d want %0d %0d",
                             i, rd_addr[i], rd_cyc[i], 10 + i, 1 + 4 * i);
                end
            end
        end
        cmp++; if (bt_data.size() !== 8) begin mism++;
            $display("FAIL multi_nbeats: got %0d want 8", bt_data.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                exp_d = (i % 2 == 0) ? 32'h50000000 : 32'hA0000000;
                exp_d = exp_d | 32'(10 + i / 2);
                cmp++;
                if (bt_data[i] !== exp_d || bt_last[i] !== (i == 7)) begin
                    mism++;
                    $display("FAIL multi_beat%0d: got %h/%0d want %h/%0d",
                             i, bt_data[i], bt_last[i], exp_d, (i == 7));
                end
            end
        end
        cmp++; if (done_cyc !== 17) begin mism++;
            $display("FAIL multi_done_cyc: got %0d want 17", done_cyc); end
    endtask

    task automatic test_stall;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h50000002;
        exp_d[1] = 32'hA0000002;
        exp_d[2] = 32'h50000003;
        exp_d[3] = 32'hA0000003;
        dump(9'd2, 9'd3, 1, 0);
        cmp++; if (timeout !== 1'b0) begin mism++;
            $display("FAIL stall_timeout: got %0d want 0", timeout); end
        cmp++; if (stall_cyc !== 6) begin mism++;
            $display("FAIL stall_cycles: got %0d want 6", stall_cyc); end
        cmp++; if (stall_viol !== 0) begin mism++;
            $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
        cmp++; if (stall_read !== 0) begin mism++;
            $display("FAIL stall_read: got %0d reads want 0", stall_read); end
        cmp++; if (bt_data.size() !== 4) begin mism++;
            $display("FAIL stall_nbeats: got %0d want 4", bt_data.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                cmp++;
                if (bt_data[i] !== exp_d[i] || bt_last[i] !== (i == 3)) begin
                    mism++;
                    $display("FAIL stall_beat%0d: got %h/%0d want %h/%0d",
                             i, bt_data[i], bt_last[i], exp_d[i], (i == 3));
                end
            end
        end
        cmp++; if (done_cyc !== 15) begin mism++;
            $display("FAIL stall_done_cyc: got %0d want 15", done_cyc); end
    endtask

    task automatic test_top_addr;
        int extra;
        dump(9'd511, 9'd511, 0, 0);
        cmp++; if (rd_addr.size() !== 1) begin mism++;
            $display("FAIL top_nreads: got %0d want 1", rd_addr.size()); end
        else begin
            cmp++; if (rd_addr[0] !== 9'd511) begin mism++;
                $display("FAIL top_read: got %0d want 511", rd_addr[0]); end
        end
        cmp++; if (bt_data.size() !== 2) begin mism++;
            $display("FAIL top_nbeats: got %0d want 2", bt_data.size()); end
        else begin
            cmp++; if (bt_data[1] !== 32'hA00001FF || bt_last[1] !== 1'b1) begin
                mism++;
                $display("FAIL top_beat1: got %h/%0d want a00001ff/1",
                         bt_data[1], bt_last[1]); end
        end
        cmp++; if (done_cyc !== 5) begin mism++;
            $display("FAIL top_done_cyc: got %0d want 5", done_cyc); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (read_o || busy_o) extra++;
        end
        cmp++; if (extra !== 0) begin mism++;
            $display("FAIL top_no_wrap: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_empty;
        dump(9'd20, 9'd19, 0, 0);
        cmp++; if (rd_addr.size() !== 0) begin mism++;
            $display("FAIL empty_reads: got %0d want 0", rd_addr.size()); end
        cmp++; if (valid_cnt !== 0) begin mism++;
            $display("FAIL empty_valid: got %0d want 0", valid_cnt); end
        cmp++; if (done_cyc !== 1) begin mism++;
            $display("FAIL empty_done_cyc: got %0d want 1", done_cyc); end
    endtask

    task automatic test_reset_mid;
        step();
        rd_start_addr_i = 9'd0;
        rd_end_addr_i   = 9'd7;
        start_i         = 1'b1;
        out_ready_i     = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            start_i = 1'b0;
        end
        cmp++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'hA0000002 ||
            out_last_o !== 1'b0) begin
            mism++;
            $display("FAIL mid_in_send_hi: got v%0d %h l%0d want v1 a0000002 l0",
                     out_valid_o, out_data_o, out_last_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        cmp++;
        if ({read_o, r_addr_o, out_valid_o, out_data_o, out_last_o,
             busy_o, done_o} !== '0) begin
            mism++;
            $display("FAIL mid_reset_outs: got rd%0d a%0d v%0d d%h l%0d b%0d dn%0d want all 0",
                     read_o, r_addr_o, out_valid_o, out_data_o, out_last_o,
                     busy_o, done_o);
        end
        dump(9'd0, 9'd0, 0, 0);
        cmp++; if (done_cyc !== 5) begin mism++;
            $display("FAIL mid_restart_done: got %0d want 5", done_cyc); end
        cmp++; if (bt_data.size() !== 2) begin mism++;
            $display("FAIL mid_restart_nbeats: got %0d want 2", bt_data.size()); end
        else begin
            cmp++;
            if (bt_data[0] !== 32'h50000000 || bt_data[1] !== 32'hA0000000) begin
                mism++;
                $display("FAIL mid_restart_data: got %h %h want 50000000 a0000000",
                         bt_data[0], bt_data[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++)
            mem[i] = {32'hA0000000 | 32'(i), 32'h50000000 | 32'(i)};
        mem[5] = 64'hDEADBEEF_12345678;
        r_data_i        = '0;
        start_i         = 1'b0;
        rd_start_addr_i = '0;
        rd_end_addr_i   = '0;
        out_ready_i     = 1'b1;
        #1;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_top_addr();
        test_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
